// File: rtl/bus_arb_pkg.sv
// Shared state encoding and sizing helpers for the round-robin bus arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRIVE = 2'd2,
    TURN  = 2'd3
  } arb_state_t;

  localparam int HOLD_W = 8;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr, with wrap.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   winner,
  output logic            valid
);

  logic [NREQ-1:0] rot;
  logic [IW-1:0]   off;
  logic [IW:0]     sum;

  // Rotating by ptr turns the wrapped search into a plain lowest-bit search.
  assign rot = NREQ'({req, req} >> ptr);

  always_comb begin
    valid = 1'b0;
    off   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        valid = 1'b1;
        off   = IW'(i);
      end
    end
  end

  assign sum    = {1'b0, ptr} + {1'b0, off};
  assign winner = (sum >= (IW+1)'(NREQ)) ? IW'(sum - (IW+1)'(NREQ)) : sum[IW-1:0];

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: grant, then drive enable, with one turnaround cycle between owners.
// Optional forced release of a non-locked owner after TIMEOUT drive cycles: BUS_ARB_TIMEOUT_EN.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter  int NREQ    = 4,
  parameter  int TIMEOUT = 15,
  localparam int IW      = idx_w(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] lock,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] oe,
  output logic [IW-1:0]   owner,
  output logic            busy,
  output logic            timeout_evt
);

  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  arb_state_t    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] nxt_ptr;
  logic [IW-1:0] pick_w;
  logic          pick_vld;
  logic          own_req;
  logic          preempt;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick_w),
    .valid  (pick_vld)
  );

  assign own_req = req[owner];
  assign nxt_ptr = (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);

`ifdef BUS_ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] hold;
  logic              tevt;

  assign preempt     = (hold >= HOLD_W'(TIMEOUT)) && !lock[owner] && |(req & ~grant);
  assign timeout_evt = tevt;
`else
  logic unused_cfg;

  assign preempt     = 1'b0;
  assign timeout_evt = 1'b0;
  assign unused_cfg  = ^{lock, HOLD_W'(TIMEOUT)};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      grant <= '0;
      oe    <= '0;
      owner <= '0;
      busy  <= 1'b0;
      ptr   <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
      hold  <= '0;
      tevt  <= 1'b0;
`endif
    end else begin
`ifdef BUS_ARB_TIMEOUT_EN
      tevt <= 1'b0;
`endif
      case (state)
        IDLE, TURN: begin
          if (pick_vld) begin
            state <= SETUP;
            grant <= ONE << pick_w;
            owner <= pick_w;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        SETUP: begin
          if (own_req) begin
            state <= DRIVE;
            oe    <= grant;
`ifdef BUS_ARB_TIMEOUT_EN
            hold  <= HOLD_W'(1);
`endif
          end else begin
            // Cancelled before driving: oe never rises for this owner.
            state <= TURN;
            grant <= '0;
            ptr   <= nxt_ptr;
          end
        end
        DRIVE: begin
          if (!own_req || preempt) begin
            state <= TURN;
            grant <= '0;
            oe    <= '0;
            ptr   <= nxt_ptr;
`ifdef BUS_ARB_TIMEOUT_EN
            tevt  <= own_req & preempt;
`endif
          end else begin
`ifdef BUS_ARB_TIMEOUT_EN
            if (hold != '1) hold <= hold + HOLD_W'(1);
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Round-robin arbiter for the shared 8-bit data bus. Requesters include the control-path sequencer, the IO port and a loader/debug master. Issues a one-hot grant, then a separate one-hot bus output-enable. A mandatory turnaround cycle between owners guarantees at most one driver and no overlap. Sits beside the state machine and signal controller; its oe outputs gate each master's tri-state drive onto the bus.

Parameters:
NREQ, 4, number of requesters; legal range 2..8.
TIMEOUT, 15, maximum DRIVE cycles before forced release; legal range 1..255. Used only with the optional feature.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
req  input  NREQ  per-requester bus request, level; held while bus is needed.
lock  input  NREQ  per-requester lock; suppresses timeout preemption for the current owner.
grant  output  NREQ  one-hot grant; bus reserved for this requester.
oe  output  NREQ  one-hot bus drive enable; subset of grant.
owner  output  $clog2(NREQ)  index of current/last granted requester.
busy  output  1  high in SETUP, DRIVE or TURN.
timeout_evt  output  1  single-cycle pulse on forced release.

Behaviour:
- Reset (reset=0, async): state=IDLE, grant=0, oe=0, owner=0, busy=0, timeout_evt=0, rr pointer=0, hold counter=0. Outputs drop immediately, not at the next edge.
- All outputs are registered.
- FSM states: IDLE, SETUP, DRIVE, TURN.
- IDLE:
  - grant=0, oe=0.
  - If any req is high at an edge, the winner is the first requester with req high, searching upward from the rr pointer with wrap.
  - Next: SETUP, grant[w]=1, owner=w.
- SETUP (exactly 1 cycle):
  - grant[w]=1, oe=0.
  - If req[w]=1: go to DRIVE, oe[w]=1, hold counter=1.
  - If req[w]=0 (cancel): go to TURN; oe is never asserted.
- DRIVE:
  - grant[w]=1, oe[w]=1.
  - req[w]=0 at an edge: go to TURN.
  - Otherwise stay; hold counter increments and saturates at 255.
- TURN (exactly 1 cycle):
  - grant=0, oe=0.
  - rr pointer = (w+1) mod NREQ.
  - Next edge: if any req is high, pick the new winner using the updated pointer and go to SETUP. Otherwise go to IDLE.
- Latency: req high before edge k gives grant after edge k and oe after edge k+1. Release: req low before edge m gives oe=0 after edge m. Minimum gap between two owners' oe is 2 cycles (TURN + SETUP).
- Simultaneous requests are resolved by the rr pointer only. Requests from non-owners during DRIVE/TURN have no effect until the next pick.
- lock is ignored in IDLE/SETUP/TURN.
- Invariants, every cycle:
  - oe is one-hot or zero.
  - grant is one-hot or zero.
  - oe & ~grant == 0.
  - busy == (state != IDLE).

Optional Feature:
BUS_ARB_TIMEOUT_EN.
- Defined: in DRIVE, if hold counter ≥ TIMEOUT, lock[w]=0 and any other req is high, then go to TURN and pulse timeout_evt for one cycle, coincident with TURN. If lock[w]=1 the owner keeps the bus indefinitely.
- Undefined: no preemption; the owner releases only by dropping req. timeout_evt is tied to 0. The hold counter and TIMEOUT are not synthesised.

Decomposition:
- Package bus_arb_pkg holds:
  - the state enum (IDLE, SETUP, DRIVE, TURN) as 2-bit encoding;
  - the index-width function/constant for $clog2(NREQ);
  - the hold counter width (8).
- Sub-module rr_pick: combinational round-robin picker. Inputs: req vector and pointer. Outputs: winner index and valid. Instantiated once.

Test Plan:
1. NREQ=4, only req[0]=1 from cycle 0 → grant=0001 after edge 1, oe=0001 after edge 2. Drop req[0] at cycle 5 → oe=0000 after edge 6, grant=0000 (TURN), then IDLE, busy=0.
2. req=0101 at once, pointer 0 → req[0] served first. Release → one TURN cycle, then grant=0100 (SETUP), then oe=0100. Pointer=1 during the second grant.
3. Fairness: all req high, each owner drops req after 3 oe cycles and reasserts 1 cycle later → grant order 0,1,2,3,0, each oe window exactly 3 cycles, never overlapping.
4. BUS_ARB_TIMEOUT_EN, TIMEOUT=15: req[0] held, req[1] high, lock=0 → oe[0] high for exactly 15 cycles, timeout_evt=1 for one cycle, req[1] gets oe 2 cycles later. Repeat with lock[0]=1 → oe[0] stays high for 100 cycles, timeout_evt=0.
5. Assert reset low mid-DRIVE, between edges → grant/oe/busy=0 immediately. After release, the pointer is 0 and req[1] and req[3] both high → req[1] wins.
6. Cancel: req[2] pulses high for exactly 1 cycle → SETUP with grant=0100, oe never asserted, then TURN, then IDLE. The invariant checker (oe/grant one-hot, oe ⊆ grant) passes on all tests.
